pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 20 ++
 rtl/pc_ras.sv | 51 +++++
 rtl/pc_sequencer.sv | 110 +++++++++++
 tb/tb_pc_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and default constants for the program-counter sequencer.
package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    SEL_RST,
    SEL_HOLD,
    SEL_RET,
    SEL_CALL,
    SEL_JMP,
    SEL_BR,
    SEL_INC
  } pc_sel_e;

  localparam int DEF_PC_W      = 32;
  localparam int DEF_INC       = 4;
  localparam int DEF_RST_VEC   = 0;
  localparam int DEF_OFF_W     = 16;
  localparam int DEF_RAS_DEPTH = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
module pc_ras #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [IDX_W-1:0] wr_ptr;
  logic [IDX_W-1:0] wr_ptr_inc;
  logic [IDX_W-1:0] top_idx;
  logic [CNT_W-1:0] count;

  // Pointer arithmetic wraps at DEPTH, which need not be a power of two.
  assign wr_ptr_inc = (wr_ptr == IDX_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
  assign top_idx    = (wr_ptr == '0) ? IDX_W'(DEPTH - 1) : wr_ptr - 1'b1;

  assign top   = mem[top_idx];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr_inc;
      if (!full) count <= count + 1'b1;
    end else if (pop && !empty) begin
      wr_ptr <= top_idx;
      count  <= count - 1'b1;
    end
  end

  // Entries carry no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with branch, jump, call/return and stall.
// Define PC_SEQUENCER_RAS_EN to build the return-address stack.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              PC_W      = DEF_PC_W,
  parameter int              INC       = DEF_INC,
  parameter logic [PC_W-1:0] RST_VEC   = PC_W'(DEF_RST_VEC),
  parameter int              OFF_W     = DEF_OFF_W,
  parameter int              RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    br_taken,
  input  logic signed [OFF_W-1:0] br_offset,
  input  logic                    jmp,
  input  logic                    call,
  input  logic                    ret,
  input  logic        [PC_W-1:0]  jmp_target,
  output logic        [PC_W-1:0]  out_pc,
  output logic        [PC_W-1:0]  next_pc,
  output logic                    ras_empty,
  output logic                    ras_full,
  output logic                    err
);

  pc_sel_e                sel;
  logic                   set_err;
  logic signed [PC_W-1:0] br_sext;
  logic        [PC_W-1:0] pc_inc;
  logic        [PC_W-1:0] pc_br;
  logic        [PC_W-1:0] ras_top;
  logic                   ras_empty_i;
  logic                   ras_full_i;

  assign br_sext = PC_W'(br_offset);
  assign pc_inc  = out_pc + PC_W'(INC);
  assign pc_br   = out_pc + br_sext;

  // Source select in priority order; set_err marks the edge that raises err.
  always_comb begin
    sel     = SEL_INC;
    set_err = 1'b0;
    if (rst) begin
      sel = SEL_RST;
    end else if (stall) begin
      sel = SEL_HOLD;
    end else if (call && ret) begin
      set_err = 1'b1;
    end else if (ret) begin
`ifdef PC_SEQUENCER_RAS_EN
      if (ras_empty_i) set_err = 1'b1;
      else             sel     = SEL_RET;
`endif
    end else if (call) begin
`ifdef PC_SEQUENCER_RAS_EN
      sel = SEL_CALL;
`else
      sel = SEL_JMP;
`endif
    end else if (jmp) begin
      sel = SEL_JMP;
    end else if (br_taken) begin
      sel = SEL_BR;
    end
  end

  always_comb begin
    next_pc = pc_inc;
    case (sel)
      SEL_RST:            next_pc = RST_VEC;
      SEL_HOLD:           next_pc = out_pc;
      SEL_RET:            next_pc = ras_top;
      SEL_CALL, SEL_JMP:  next_pc = jmp_target;
      SEL_BR:             next_pc = pc_br;
      default:            next_pc = pc_inc;
    endcase
  end

  always_ff @(posedge clk) begin
    out_pc <= next_pc;
    if (rst)          err <= 1'b0;
    else if (set_err) err <= 1'b1;
  end

`ifdef PC_SEQUENCER_RAS_EN
  pc_ras #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (sel == SEL_CALL),
    .pop       (sel == SEL_RET),
    .push_data (pc_inc),
    .top       (ras_top),
    .full      (ras_full_i),
    .empty     (ras_empty_i)
  );
`else
  assign ras_top     = '0;
  assign ras_full_i  = 1'b0;
  assign ras_empty_i = 1'b1;
`endif

  assign ras_empty = ras_empty_i;
  assign ras_full  = ras_full_i;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_pc_sequencer;

  localparam int PC_W  = 32;
  localparam int OFF_W = 16;
  localparam int DEPTH = 4;
  localparam int INC   = 4;
  localparam logic [31:0] RST_VEC = 32'h0;
`ifdef PC_SEQUENCER_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst, stall, br_taken, jmp, call, ret;
  logic signed [OFF_W-1:0] br_offset;
  logic        [PC_W-1:0]  jmp_target;
  logic        [PC_W-1:0]  out_pc, next_pc;
  logic                    ras_empty, ras_full, err;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_pc;
  bit          m_err;
  bit          m_valid = 1'b0;
  logic [31:0] stk[$];

  pc_sequencer #(
    .PC_W      (PC_W),
    .INC       (INC),
    .RST_VEC   (RST_VEC),
    .OFF_W     (OFF_W),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_offset  (br_offset),
    .jmp        (jmp),
    .call       (call),
    .ret        (ret),
    .jmp_target (jmp_target),
    .out_pc     (out_pc),
    .next_pc    (next_pc),
    .ras_empty  (ras_empty),
    .ras_full   (ras_full),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_next();
    if (rst)          return RST_VEC;
    if (stall)        return m_pc;
    if (call && ret)  return m_pc + INC;
    if (ret)          return (RAS && stk.size() > 0) ? stk[$] : m_pc + INC;
    if (call || jmp)  return jmp_target;
    if (br_taken)     return m_pc + int'(br_offset);
    return m_pc + INC;
  endfunction

  always @(posedge clk) begin
    logic [31:0] np;
    np = model_next();
    if (rst) begin
      stk.delete();
      m_err   = 1'b0;
      m_valid = 1'b1;
    end else if (!stall) begin
      if (call && ret) m_err = 1'b1;
      else if (ret && RAS) begin
        if (stk.size() == 0) m_err = 1'b1;
        else void'(stk.pop_back());
      end else if (call && RAS) begin
        if (stk.size() == DEPTH) void'(stk.pop_front());
        stk.push_back(m_pc + INC);
      end
    end
    m_pc = np;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_out_pc",    out_pc,    m_pc);
      chk("cyc_next_pc",   next_pc,   model_next());
      chk("cyc_ras_empty", ras_empty, stk.size() == 0);
      chk("cyc_ras_full",  ras_full,  stk.size() == DEPTH);
      chk("cyc_err",       err,       m_err);
    end
  end

  task automatic idle();
    rst = 0; stall = 0; br_taken = 0; br_offset = '0;
    jmp = 0; call = 0; ret = 0; jmp_target = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_jmp(input logic [31:0] t);
    idle(); jmp = 1; jmp_target = t; step(); idle();
  endtask

  task automatic do_reset();
    idle(); rst = 1; step(); idle();
  endtask

  initial begin
    idle();
    rst = 1; stall = 1; call = 1; jmp_target = 32'h1234;
    step();
    chk("rst_pc0", out_pc, 32'h0);
    step();
    chk("rst_pc1", out_pc, 32'h0);
    chk("rst_empty", ras_empty, 1'b1);
    chk("rst_full", ras_full, 1'b0);
    chk("rst_err", err, 1'b0);
    idle();
    step(); chk("free_4", out_pc, 32'd4);
    step(); chk("free_8", out_pc, 32'd8);
    step(); chk("free_12", out_pc, 32'd12);

    go_jmp(32'hFFFF_FFF8);
    chk("jmp_top", out_pc, 32'hFFFF_FFF8);
    step(); chk("wrap_fc", out_pc, 32'hFFFF_FFFC);
    step(); chk("wrap_0", out_pc, 32'h0);
    step(); chk("wrap_4", out_pc, 32'h4);

    go_jmp(32'h100);
    br_taken = 1; br_offset = -16'sd8; step(); idle();
    chk("br_neg8", out_pc, 32'hF8);
    go_jmp(32'h100);
    br_taken = 1; br_offset = -16'sd8; jmp = 1; jmp_target = 32'h400; step(); idle();
    chk("jmp_over_br", out_pc, 32'h400);

    do_reset();
    go_jmp(32'h10);
    for (int i = 0; i < 5; i++) begin
      call = 1; jmp_target = 32'h20 + 32'(i) * 32'h10; step(); idle();
    end
    if (RAS) begin
      chk("ras_full5", ras_full, 1'b1);
      chk("ras_err5", err, 1'b0);
      for (int i = 0; i < 4; i++) begin
        ret = 1; step(); idle();
        chk("ret_addr", out_pc, 32'h54 - 32'(i) * 32'h10);
      end
      chk("ret_err_pre", err, 1'b0);
      ret = 1; step(); idle();
      chk("ret_empty_pc", out_pc, 32'h28);
      chk("ret_empty_err", err, 1'b1);
      chk("ret_empty_flag", ras_empty, 1'b1);
    end else begin
      chk("call_as_jmp", out_pc, 32'h60);
      chk("noras_empty", ras_empty, 1'b1);
      ret = 1; step(); idle();
      chk("ret_as_inc", out_pc, 32'h64);
      chk("noras_err", err, 1'b0);
    end

    do_reset();
    go_jmp(32'h300);
    call = 1; jmp_target = 32'h500; step(); idle();
    stall = 1; call = 1; jmp_target = 32'h700;
    #1 chk("stall_next", next_pc, 32'h500);
    step(); idle();
    chk("stall_pc", out_pc, 32'h500);
    chk("stall_empty", ras_empty, !RAS);
    chk("stall_err", err, 1'b0);
    ret = 1; step(); idle();
    chk("stall_stack", out_pc, RAS ? 32'h304 : 32'h504);

    go_jmp(32'h200);
    call = 1; ret = 1; jmp_target = 32'h900; step(); idle();
    chk("conf_pc", out_pc, 32'h204);
    chk("conf_err", err, 1'b1);
    step(); chk("err_sticky", err, 1'b1);
    do_reset();
    chk("conf_rst_pc", out_pc, RST_VEC);
    chk("conf_rst_err", err, 1'b0);
    chk("conf_rst_empty", ras_empty, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      stall      = ($urandom_range(0, 7) == 0);
      call       = ($urandom_range(0, 5) == 0);
      ret        = ($urandom_range(0, 5) == 0);
      jmp        = ($urandom_range(0, 7) == 0);
      br_taken   = ($urandom_range(0, 2) == 0);
      br_offset  = OFF_W'($urandom);
      jmp_target = $urandom & 32'hFFFF_FFFC;
      step();
    end
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
